// File: rtl/fifo_rd_if.sv
// Read-side bus of the async FIFO: memory read port, pointer exchange and valid/ready output.
// ralmost_empty exists only when FIFO_RD_AEMPTY_EN is defined.
interface fifo_rd_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH:0]   rq2_wptr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
`ifdef FIFO_RD_AEMPTY_EN
    logic                  ralmost_empty;

    modport master (
        input  rq2_wptr, rdata, dout_ready,
        output raddr, rptr, rempty, dout, dout_valid, ralmost_empty
    );
    modport slave (
        output rq2_wptr, rdata, dout_ready,
        input  raddr, rptr, rempty, dout, dout_valid, ralmost_empty
    );
`else
    modport master (
        input  rq2_wptr, rdata, dout_ready,
        output raddr, rptr, rempty, dout, dout_valid
    );
    modport slave (
        output rq2_wptr, rdata, dout_ready,
        input  raddr, rptr, rempty, dout, dout_valid
    );
`endif
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: binary/Gray read pointer, rempty, registered valid/ready output.
// Define FIFO_RD_AEMPTY_EN to add the ralmost_empty flag (threshold AEMPTY_THRESH words).
module fifo_rd_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input logic       rclk,
    input logic       rrst,
    fifo_rd_if.master bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         rbin_q;
    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         rbinnext;
    logic [PW-1:0]         rgraynext;
    logic                  rempty_q;
    logic                  dout_valid_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  pop;

    // Pop only when a word is stored and the output stage is free or being drained.
    always_comb begin
        pop       = !rempty_q && (!dout_valid_q || bus.dout_ready);
        rbinnext  = rbin_q + {{ADDR_WIDTH{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            rbin_q   <= rbinnext;
            rptr_q   <= rgraynext;
            // Full-width compare: pointers with differing MSBs mean full, never empty.
            rempty_q <= (rgraynext == bus.rq2_wptr);
            if (pop) begin
                dout_q       <= bus.rdata;
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.raddr      = rbin_q[ADDR_WIDTH-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rempty     = rempty_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

`ifdef FIFO_RD_AEMPTY_EN
    localparam logic [PW-1:0] AeThresh = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] rfill;
    logic          ralmost_empty_q;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(bus.rq2_wptr >> i);
        end
        rfill = wbin - rbinnext;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            ralmost_empty_q <= 1'b1;
        end else begin
            ralmost_empty_q <= (rfill <= AeThresh);
        end
    end

    assign bus.ralmost_empty = ralmost_empty_q;
`endif
endmodule
